// File: rtl/tiny_host_pkg.sv
// tiny_host_pkg: shared constants, state encoding and control decode for tiny_host_if.
// Build option: TINY_HOST_WATCHDOG_EN adds the ERR state entered on a RUN timeout.
package tiny_host_pkg;

    localparam int WORD_W       = 32;
    localparam int N_WORDS      = 7;
    localparam int OP_W         = 198;
    localparam int HDR_LAST     = 31;
    localparam int HDR_ADDR_MSB = 5;
    localparam int HDR_ADDR_LSB = 0;
    localparam int ADDR_W       = HDR_ADDR_MSB - HDR_ADDR_LSB + 1;
    localparam int CNT_W        = 3;
    localparam int WD_W         = 20;
    // Width of the final, partial operand word (bits [197:192]).
    localparam int TAIL_W       = OP_W - (N_WORDS - 1) * WORD_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RUN,
        S_READ,
        S_CAPT,
        S_SEND
`ifdef TINY_HOST_WATCHDOG_EN
        ,
        S_ERR
`endif
    } state_t;

    // Registered per-state output strobes.
    typedef struct packed {
        logic inReady;
        logic busy;
        logic coreReset;
        logic coreSel;
        logic coreW;
        logic outValid;
    } ctrl_t;

    // Value held while reset is asserted; in_ready stays low until the first clock.
    localparam ctrl_t CTRL_RESET = '{
        inReady:   1'b0,
        busy:      1'b0,
        coreReset: 1'b1,
        coreSel:   1'b1,
        coreW:     1'b0,
        outValid:  1'b0
    };

    // Output strobes for the state the FSM is about to enter.
    function automatic ctrl_t decodeCtrl(input state_t s);
        ctrl_t c;
        c.inReady   = (s == S_IDLE) || (s == S_LOAD);
        c.busy      = (s != S_IDLE);
        c.coreReset = (s != S_RUN);
        c.coreSel   = (s != S_RUN);
        c.coreW     = (s == S_WRITE);
        c.outValid  = (s == S_SEND);
        return c;
    endfunction

endpackage

// File: rtl/tiny_word_shifter.sv
// tiny_word_shifter: 198-bit operand register shared by operand assembly and result
// serialisation. Words enter at the top and move down, so the first word ends at [31:0].
module tiny_word_shifter
    import tiny_host_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [OP_W-1:0]   i_loadData,
    input  logic              i_shiftIn,
    input  logic              i_shiftInLast,
    input  logic [WORD_W-1:0] i_inWord,
    input  logic              i_shiftOut,
    output logic [OP_W-1:0]   o_data
);

    logic [OP_W-1:0] r_data;

    // Parallel load wins over shifting; the last input word only moves the register by TAIL_W bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_loadData;
        end else if (i_shiftIn) begin
            if (i_shiftInLast) begin
                r_data <= {i_inWord[TAIL_W-1:0], r_data[OP_W-1:TAIL_W]};
            end else begin
                r_data <= {i_inWord, r_data[OP_W-1:WORD_W]};
            end
        end else if (i_shiftOut) begin
            r_data <= {{WORD_W{1'b0}}, r_data[OP_W-1:WORD_W]};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/tiny_host_if.sv
// tiny_host_if: loads addressed operands into the pairing core RAM, runs the core,
// then streams one result location back out as 32-bit words.
// Build option: TINY_HOST_WATCHDOG_EN enables the RUN watchdog, the ERR state and err.
module tiny_host_if
    import tiny_host_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RES_ADDR = 6'd0,
    parameter logic [WD_W-1:0]   TIMEOUT  = 20'd1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err,
    output logic              core_reset,
    output logic              core_sel,
    output logic [ADDR_W-1:0] core_addr,
    output logic              core_w,
    output logic [OP_W-1:0]   core_data,
    input  logic [OP_W-1:0]   core_out,
    input  logic              core_done
);

    state_t            r_state;
    state_t            w_nextState;
    ctrl_t             r_ctrl;
    logic [ADDR_W-1:0] r_coreAddr;
    logic [ADDR_W-1:0] r_hdrAddr;
    logic              r_hdrLast;
    logic [CNT_W-1:0]  r_count;
    logic              r_runFirst;

    logic              w_inAccept;
    logic              w_hdrAccept;
    logic              w_outXfer;
    logic              w_lastWord;
    logic              w_shiftIn;
    logic              w_shiftOut;
    logic              w_load;
    logic [OP_W-1:0]   w_shiftData;
    logic              w_wdExpired;
    logic              w_unusedHdrBits;

    assign w_inAccept  = in_valid && r_ctrl.inReady;
    assign w_hdrAccept = (r_state == S_IDLE) && w_inAccept;
    assign w_outXfer   = r_ctrl.outValid && out_ready;
    assign w_lastWord  = (r_count == CNT_W'(N_WORDS - 1));
    assign w_shiftIn   = (r_state == S_LOAD) && w_inAccept;
    assign w_shiftOut  = (r_state == S_SEND) && w_outXfer;
    assign w_load      = (r_state == S_CAPT);

    assign w_unusedHdrBits = ^in_data[HDR_LAST-1:HDR_ADDR_MSB+1];

    tiny_word_shifter u_shifter (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_load),
        .i_loadData    (core_out),
        .i_shiftIn     (w_shiftIn),
        .i_shiftInLast (w_lastWord),
        .i_inWord      (in_data),
        .i_shiftOut    (w_shiftOut),
        .o_data        (w_shiftData)
    );

`ifdef TINY_HOST_WATCHDOG_EN
    logic [WD_W-1:0] r_wdCount;
    logic            r_err;

    assign w_wdExpired = (r_wdCount == TIMEOUT - WD_W'(1));

    // Count cycles spent in RUN, restarting from zero on every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdCount <= '0;
        end else if (r_state == S_RUN) begin
            r_wdCount <= r_wdCount + WD_W'(1);
        end else begin
            r_wdCount <= '0;
        end
    end

    // Sticky error: set on entering ERR, cleared only when the next header is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_nextState == S_ERR) begin
            r_err <= 1'b1;
        end else if (w_hdrAccept) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    logic w_unusedTimeout;

    assign w_unusedTimeout = ^TIMEOUT;
    assign w_wdExpired     = 1'b0;
    assign err             = 1'b0;
`endif

    // Next-state decision; outputs are then registered from this value so they line up with the state.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_inAccept) w_nextState = S_LOAD;
            S_LOAD:  if (w_inAccept && w_lastWord) w_nextState = S_WRITE;
            S_WRITE: w_nextState = r_hdrLast ? S_RUN : S_IDLE;
            S_RUN: begin
                if (core_done && !r_runFirst) begin
                    w_nextState = S_READ;
                end
`ifdef TINY_HOST_WATCHDOG_EN
                else if (w_wdExpired) begin
                    w_nextState = S_ERR;
                end
`endif
            end
            S_READ:  w_nextState = S_CAPT;
            S_CAPT:  w_nextState = S_SEND;
            S_SEND:  if (w_outXfer && w_lastWord) w_nextState = S_IDLE;
`ifdef TINY_HOST_WATCHDOG_EN
            S_ERR:   w_nextState = S_IDLE;
`endif
            default: w_nextState = S_IDLE;
        endcase
    end

    // Main FSM: state, registered strobes, header latch, word counter and RAM address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= CTRL_RESET;
            r_coreAddr <= '0;
            r_hdrAddr  <= '0;
            r_hdrLast  <= 1'b0;
            r_count    <= '0;
            r_runFirst <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_ctrl     <= decodeCtrl(w_nextState);
            r_runFirst <= (r_state == S_WRITE) && (w_nextState == S_RUN);

            if (w_nextState == S_WRITE) begin
                r_coreAddr <= r_hdrAddr;
            end else if (w_nextState == S_READ) begin
                r_coreAddr <= RES_ADDR;
            end

            if (w_hdrAccept) begin
                r_hdrAddr <= in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
                r_hdrLast <= in_data[HDR_LAST];
                r_count   <= '0;
            end else if (w_shiftIn || w_shiftOut) begin
                r_count <= w_lastWord ? '0 : r_count + CNT_W'(1);
            end else if (r_state == S_CAPT) begin
                r_count <= '0;
            end
        end
    end

    assign in_ready   = r_ctrl.inReady;
    assign busy       = r_ctrl.busy;
    assign core_reset = r_ctrl.coreReset;
    assign core_sel   = r_ctrl.coreSel;
    assign core_w     = r_ctrl.coreW;
    assign out_valid  = r_ctrl.outValid;
    assign core_addr  = r_coreAddr;
    assign core_data  = w_shiftData;
    assign out_data   = w_shiftData[WORD_W-1:0];

endmodule
